// File: rtl/mx_xmit.sv
// Manchester frame transmitter: preamble, SFD, LSB-first data bytes, then a constant-high EOF.
// Bytes arrive over valid/rdy; a one-byte holding register lets consecutive bytes go out back-to-back.
module mx_xmit #(
    parameter int unsigned CLK_RATE       = 100_000_000,
    parameter int unsigned BAUD           = 50_000,
    parameter int unsigned PREAMBLE_BYTES = 2,
    parameter logic [7:0]  SFD_BYTE       = 8'hD0,
    parameter int unsigned EOF_BITS       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       rdy,
    output logic       txd,
    output logic       txen
);
    localparam int unsigned BIT_CLKS = CLK_RATE / BAUD;
    localparam int unsigned CW = $clog2(BIT_CLKS);
    localparam int unsigned BW = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;
    localparam int unsigned EW = (EOF_BITS > 1) ? $clog2(EOF_BITS) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CLK_HALF  = CW'(BIT_CLKS / 2);
    localparam logic [BW-1:0] BYTE_LAST = BW'(PREAMBLE_BYTES - 1);
    localparam logic [EW-1:0] EOF_LAST  = EW'(EOF_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_EOF
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [EW-1:0] eof_cnt_q, eof_cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          txen_q, txen_d;

    logic accept;
    logic last_clk;
    logic last_bit;
    logic line_bit;
    logic sending;

    assign rdy = (state_q == S_IDLE) ||
                 (((state_q == S_PREAMBLE) || (state_q == S_SFD) || (state_q == S_DATA)) && !hold_full_q);
    assign accept   = valid && rdy;
    assign last_clk = (clk_cnt_q == CLK_LAST);
    assign last_bit = (bit_cnt_q == 3'd7);
    assign txd  = txd_q;
    assign txen = txen_q;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        eof_cnt_d   = eof_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_d      = data;
                    hold_full_d = 1'b1;
                    state_d     = S_PREAMBLE;
                    clk_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                end
            end
            S_PREAMBLE: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        if (byte_cnt_q == BYTE_LAST) begin
                            byte_cnt_d = '0;
                            state_d    = S_SFD;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_SFD: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = S_DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (accept) begin
                    hold_d      = data;
                    hold_full_d = 1'b1;
                end
                if (last_clk) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = shift_q >> 1;
                    // A byte arriving on the boundary cycle bypasses the holding register.
                    if (last_bit) begin
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            shift_d     = data;
                            hold_full_d = 1'b0;
                        end else begin
                            eof_cnt_d = '0;
                            state_d   = S_EOF;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_EOF: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    if (eof_cnt_q == EOF_LAST) begin
                        eof_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        eof_cnt_d = eof_cnt_q + EW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // txd is registered, so it is derived from the cycle being entered.
        line_bit = 1'b1;
        sending  = 1'b0;
        unique case (state_d)
            S_PREAMBLE: begin line_bit = ~bit_cnt_d[0];        sending = 1'b1; end
            S_SFD:      begin line_bit = SFD_BYTE[bit_cnt_d];  sending = 1'b1; end
            S_DATA:     begin line_bit = shift_d[0];           sending = 1'b1; end
            default:    begin line_bit = 1'b1;                 sending = 1'b0; end
        endcase
        txd_d  = sending ? (line_bit ^ (clk_cnt_d >= CLK_HALF)) : 1'b1;
        txen_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            eof_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            txen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            eof_cnt_q   <= eof_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            txen_q      <= txen_d;
        end
    end
endmodule

// File: tb/tb_mx_xmit.sv
// Directed bench for mx_xmit at 8 clocks per bit; expected line waveforms come from a frame model.
module tb_mx_xmit;
    localparam int BC = 8;
    localparam int HB = BC / 2;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       rdy;
    logic       txd;
    logic       txen;

    logic [7:0] pay [0:31];
    int n_checks;
    int n_pass;

    mx_xmit #(
        .CLK_RATE(800),
        .BAUD(100),
        .PREAMBLE_BYTES(2),
        .SFD_BYTE(8'hD0),
        .EOF_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .valid(valid),
        .rdy(rdy),
        .txd(txd),
        .txen(txen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Line level at cycle k of a frame carrying n data bytes (k=0 is the first txen cycle).
    function automatic logic exp_txd(input int k, input int n);
        logic [7:0] sfd;
        logic [7:0] by;
        logic       b;
        int         i;
        sfd = 8'hD0;
        i = k / BC;
        if (i >= 8 * (3 + n)) return 1'b1;
        if (i < 16) begin
            b = ((i % 2) == 0);
        end else if (i < 24) begin
            b = sfd[i - 16];
        end else begin
            by = pay[(i - 24) / 8];
            b  = by[(i - 24) % 8];
        end
        return b ^ ((k % BC) >= HB);
    endfunction

    task automatic start(input logic [7:0] b);
        @(negedge clk);
        pay[0] = b;
        valid  = 1'b1;
        data   = b;
        chk("rdy_idle", {31'd0, rdy}, 32'd1);
    endtask

    // Checks txd/txen every cycle of a frame; offers pay[1..n-1] from cycle late_k on.
    task automatic run_frame(input string tag, input int n, input int late_k, input bit poke);
        int L;
        int idx;
        int bad;
        int first;
        int hi;
        L = (3 + n) * 8 * BC + 2 * BC;
        idx = 1;
        bad = 0;
        first = -1;
        hi = 0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            if (txen === 1'b1) hi++;
            if ((txd !== exp_txd(k, n)) || (txen !== 1'b1)) begin
                bad++;
                if (first < 0) first = k;
            end
            if (n > 2) begin
                if (k == 100 || k == 200) chk({tag, "_rdy_busy"}, {31'd0, rdy}, 32'd0);
                if (k == 24 * BC + 8 * BC) chk({tag, "_rdy_reload"}, {31'd0, rdy}, 32'd1);
            end
            if (poke && k >= L - 10) begin
                valid = 1'b1;
                data  = 8'hEE;
                if (k == L - 10) chk({tag, "_rdy_eof"}, {31'd0, rdy}, 32'd0);
            end else if (idx < n && k >= late_k) begin
                valid = 1'b1;
                data  = pay[idx];
                if (rdy === 1'b1) idx++;
            end else begin
                valid = 1'b0;
            end
        end
        chk($sformatf("%s_txd_bad_cycles(first=%0d)", tag, first), bad, 0);
        chk({tag, "_txen_len"}, hi, L);
        chk({tag, "_xfers"}, idx, n);
        @(negedge clk);
        chk({tag, "_end_txen"}, {31'd0, txen}, 32'd0);
        chk({tag, "_end_txd"}, {31'd0, txd}, 32'd1);
        chk({tag, "_end_rdy"}, {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        for (int i = 0; i < 32; i++) pay[i] = 8'h00;
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_txen", {31'd0, txen}, 32'd0);
        chk("reset_rdy", {31'd0, rdy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single byte
        start(8'hAA);
        run_frame("single", 1, 0, 1'b0);

        // back-to-back burst of 0..23 with valid held high
        for (int i = 0; i < 24; i++) pay[i] = 8'(i);
        start(8'h00);
        run_frame("burst", 24, 0, 1'b0);

        // underrun, then valid during EOF which must wait for IDLE and start a fresh frame
        start(8'h10);
        run_frame("underrun", 1, 0, 1'b1);
        pay[0] = 8'hEE;
        run_frame("after_eof", 1, 0, 1'b0);

        // second byte offered only on the final cycle of the first byte
        pay[1] = 8'h96;
        start(8'h5A);
        run_frame("late", 2, 24 * BC + 8 * BC - 1, 1'b0);

        // reset in the middle of the SFD
        start(8'h3C);
        @(negedge clk);
        valid = 1'b0;
        repeat (150) @(negedge clk);
        chk("pre_rst_txen", {31'd0, txen}, 32'd1);
        chk("pre_rst_txd", {31'd0, txd}, {31'd0, exp_txd(150, 1)});
        #2 rst = 1'b1;
        #1;
        chk("rst_async_txd", {31'd0, txd}, 32'd1);
        chk("rst_async_txen", {31'd0, txen}, 32'd0);
        chk("rst_async_rdy", {31'd0, rdy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        start(8'hC3);
        run_frame("post_rst", 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
